pong_match_ctrl: RTL

Match/rally sequencer for the pong core. It gates ball motion and chooses serve side and ball direction. It keeps both players' scores (0..WIN_SCORE) and declares the winner. Inputs are the paddle and goal collision levels, the serve buttons and the frame tick (vsync falling-edge pulse). Outputs drive the ball position update, the score sprites and the audio beep logic.

---
 rtl/pong_pkg.sv | 25 ++
 rtl/pong_match_ctrl_if.sv | 44 ++++
 rtl/pong_edge_det.sv | 26 ++
 rtl/pong_match_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// -----------------------------------------------------------------------------
// pong_pkg
// Shared types and constants for the pong match sequencer:
//   state_e         FSM state encodings (IDLE..OVER, codes 0..4)
//   WIN_NONE/P1/P2  winner output encodings
//   DIR_LEFT/RIGHT  ball direction encodings
// -----------------------------------------------------------------------------
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/pong_match_ctrl_if.sv
// -----------------------------------------------------------------------------
// pong_match_ctrl_if
// Bundles the sequencer's event inputs and match outputs.
//   master : the surrounding game logic (drives events, reads match status)
//   slave  : pong_match_ctrl (reads events, drives match status)
// Inputs : frame_tick, start, p1_srv, p2_srv, p1_hit, p2_hit, out_left, out_right
// Outputs: state[2:0], ball_run, ball_dir, ball_load, serve_side,
//          score_p1[3:0], score_p2[3:0], winner[1:0], point_evt, speed[1:0]
// -----------------------------------------------------------------------------
interface pong_match_ctrl_if;

    logic       frame_tick;
    logic       start;
    logic       p1_srv;
    logic       p2_srv;
    logic       p1_hit;
    logic       p2_hit;
    logic       out_left;
    logic       out_right;

    logic [2:0] state;
    logic       ball_run;
    logic       ball_dir;
    logic       ball_load;
    logic       serve_side;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic [1:0] winner;
    logic       point_evt;
    logic [1:0] speed;

    modport master (
        output frame_tick, start, p1_srv, p2_srv, p1_hit, p2_hit, out_left, out_right,
        input  state, ball_run, ball_dir, ball_load, serve_side,
               score_p1, score_p2, winner, point_evt, speed
    );

    modport slave (
        input  frame_tick, start, p1_srv, p2_srv, p1_hit, p2_hit, out_left, out_right,
        output state, ball_run, ball_dir, ball_load, serve_side,
               score_p1, score_p2, winner, point_evt, speed
    );

endinterface

// File: rtl/pong_edge_det.sv
// -----------------------------------------------------------------------------
// pong_edge_det
// W-bit rising-edge detector: rise_o = in_i & ~prev.
// prev resets to all ones so a level already high at reset release is not
// mistaken for a fresh press.
// Ports: clk, rst (async, active-high), in_i[W-1:0], rise_o[W-1:0]
// -----------------------------------------------------------------------------
module pong_edge_det #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_i,
    output logic [W-1:0] rise_o
);

    logic [W-1:0] prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev_q <= '1;
        else     prev_q <= in_i;
    end

    assign rise_o = in_i & ~prev_q;

endmodule

// File: rtl/pong_match_ctrl.sv
// -----------------------------------------------------------------------------
// pong_match_ctrl
// Match/rally sequencer for the pong core: gates ball motion, picks serve side
// and ball direction, keeps both scores and declares the winner.
// Ports: clk, rst (async, active-high), bus (pong_match_ctrl_if.slave).
// Parameters: WIN_SCORE (1..9), PAUSE_FRAMES (0..255), HITS_PER_LEVEL (>=1).
// Optional build macro PONG_RALLY_SPEEDUP_EN: when defined, speed steps up
// every HITS_PER_LEVEL accepted paddle hits (saturating at 3) and clears on
// each serve; when undefined, speed is tied to zero.
// All outputs are registered; an event seen at clock edge k is reflected in the
// outputs right after edge k.
// -----------------------------------------------------------------------------
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE      = 9,
    parameter int PAUSE_FRAMES   = 60,
    parameter int HITS_PER_LEVEL = 4
) (
    input  logic             clk,
    input  logic             rst,
    pong_match_ctrl_if.slave bus
);

    localparam logic [3:0] WIN_S   = 4'(WIN_SCORE);
    localparam logic [7:0] PAUSE_S = 8'(PAUSE_FRAMES);

    // Edge detection for all seven event inputs
    logic [6:0] ev_lvl;
    logic [6:0] ev_rise;

    assign ev_lvl = {bus.out_right, bus.out_left, bus.p2_hit, bus.p1_hit,
                     bus.p2_srv, bus.p1_srv, bus.start};

    pong_edge_det #(.W(7)) u_edge (
        .clk    (clk),
        .rst    (rst),
        .in_i   (ev_lvl),
        .rise_o (ev_rise)
    );

    logic r_start, r_p1_srv, r_p2_srv, r_p1_hit, r_p2_hit, r_out_l, r_out_r;
    assign {r_out_r, r_out_l, r_p2_hit, r_p1_hit, r_p2_srv, r_p1_srv, r_start} = ev_rise;

    // Registered state and outputs
    state_e     state_q;
    logic       ball_run_q;
    logic       ball_dir_q;
    logic       ball_load_q;
    logic       serve_side_q;
    logic [3:0] score_p1_q;
    logic [3:0] score_p2_q;
    logic [1:0] winner_q;
    logic       point_evt_q;
    logic [7:0] pause_q;

    // Event qualification shared by the FSM and the speed-up logic.
    // start has top priority; a goal beats any paddle hit in the same cycle.
    logic srv_rise;
    logic serve_go;
    logic goal_any;
    logic hit_acc;
    logic [3:0] p1_inc;
    logic [3:0] p2_inc;

    assign srv_rise = serve_side_q ? r_p2_srv : r_p1_srv;
    assign serve_go = !r_start && (state_q == ST_SERVE) && srv_rise;
    assign goal_any = r_out_l || r_out_r;
    assign hit_acc  = !r_start && (state_q == ST_PLAY) && !goal_any &&
                      ((r_p1_hit && ball_dir_q == DIR_LEFT) ||
                       (r_p2_hit && ball_dir_q == DIR_RIGHT));
    assign p1_inc   = (score_p1_q == WIN_S) ? score_p1_q : score_p1_q + 4'd1;
    assign p2_inc   = (score_p2_q == WIN_S) ? score_p2_q : score_p2_q + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ball_run_q   <= 1'b0;
            ball_dir_q   <= DIR_LEFT;
            ball_load_q  <= 1'b0;
            serve_side_q <= 1'b0;
            score_p1_q   <= 4'd0;
            score_p2_q   <= 4'd0;
            winner_q     <= WIN_NONE;
            point_evt_q  <= 1'b0;
            pause_q      <= 8'd0;
        end else begin
            // Pulse outputs default low every cycle
            ball_load_q <= 1'b0;
            point_evt_q <= 1'b0;

            if (r_start) begin
                score_p1_q   <= 4'd0;
                score_p2_q   <= 4'd0;
                winner_q     <= WIN_NONE;
                serve_side_q <= 1'b0;
                ball_run_q   <= 1'b0;
                ball_load_q  <= 1'b1;
                state_q      <= ST_SERVE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        ball_run_q <= 1'b0;
                    end

                    ST_SERVE: begin
                        if (serve_go) begin
                            ball_run_q <= 1'b1;
                            // Player 1 serves rightwards, player 2 leftwards
                            ball_dir_q <= ~serve_side_q;
                            state_q    <= ST_PLAY;
                        end
                    end

                    ST_PLAY: begin
                        if (r_out_l) begin
                            // Left goal: player 2 scores, player 1 serves next
                            score_p2_q   <= p2_inc;
                            point_evt_q  <= 1'b1;
                            ball_run_q   <= 1'b0;
                            serve_side_q <= 1'b0;
                            if (p2_inc == WIN_S) begin
                                winner_q <= WIN_P2;
                                state_q  <= ST_OVER;
                            end else begin
                                pause_q  <= PAUSE_S;
                                state_q  <= ST_POINT;
                            end
                        end else if (r_out_r) begin
                            // Right goal: player 1 scores, player 2 serves next
                            score_p1_q   <= p1_inc;
                            point_evt_q  <= 1'b1;
                            ball_run_q   <= 1'b0;
                            serve_side_q <= 1'b1;
                            if (p1_inc == WIN_S) begin
                                winner_q <= WIN_P1;
                                state_q  <= ST_OVER;
                            end else begin
                                pause_q  <= PAUSE_S;
                                state_q  <= ST_POINT;
                            end
                        end else if (hit_acc) begin
                            ball_dir_q <= ~ball_dir_q;
                        end
                    end

                    ST_POINT: begin
                        if (pause_q == 8'd0) begin
                            ball_load_q <= 1'b1;
                            state_q     <= ST_SERVE;
                        end else if (bus.frame_tick) begin
                            pause_q <= pause_q - 8'd1;
                        end
                    end

                    ST_OVER: begin
                        ball_run_q <= 1'b0;
                    end

                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef PONG_RALLY_SPEEDUP_EN
    localparam logic [7:0] HPL_M1 = 8'(HITS_PER_LEVEL - 1);

    logic [7:0] hit_cnt_q;
    logic [1:0] speed_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q <= 8'd0;
            speed_q   <= 2'd0;
        end else if (serve_go) begin
            hit_cnt_q <= 8'd0;
            speed_q   <= 2'd0;
        end else if (hit_acc) begin
            if (hit_cnt_q == HPL_M1) begin
                hit_cnt_q <= 8'd0;
                if (speed_q != 2'd3) speed_q <= speed_q + 2'd1;
            end else begin
                hit_cnt_q <= hit_cnt_q + 8'd1;
            end
        end
    end

    assign bus.speed = speed_q;
`else
    assign bus.speed = 2'd0;
`endif

    assign bus.state      = state_q;
    assign bus.ball_run   = ball_run_q;
    assign bus.ball_dir   = ball_dir_q;
    assign bus.ball_load  = ball_load_q;
    assign bus.serve_side = serve_side_q;
    assign bus.score_p1   = score_p1_q;
    assign bus.score_p2   = score_p2_q;
    assign bus.winner     = winner_q;
    assign bus.point_evt  = point_evt_q;

endmodule
